// File: rtl/cpu6_ifu.sv
// cpu6_ifu: instruction fetch unit with credit-limited request issue,
// registered in-order instruction FIFO, redirect flush and halt control.
module cpu6_ifu #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            excp_flush_ena,
  input  logic [XLEN-1:0] excp_flush_pc,
  input  logic            br_redirect_ena,
  input  logic [XLEN-1:0] br_redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            halt_req,
  output logic            halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    RUN,
    HALTING,
    HALTED
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            redir;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] tgt;
  logic [CW:0]     credit;
  logic            accept;
  logic            push;
  logic            pop;

  always_comb begin
    redir  = excp_flush_ena | br_redirect_ena;
    sel    = excp_flush_ena ? excp_flush_pc
                            : br_redirect_pc;
    tgt    = sel & ~XLEN'(3);
    credit = {1'b0, out_q} + {1'b0, cnt_q};

    imem_req_valid = reset
                   & (state_q == RUN)
                   & ~redir
                   & (int'(credit) < DEPTH);
    imem_req_addr  = fpc_q;
    accept         = imem_req_valid & imem_req_ready;

    instr_valid = (cnt_q != '0);
    instr       = instr_valid ? data_mem[rptr_q] : '0;
    instr_pc    = instr_valid ? pc_mem[rptr_q] : '0;
    halted      = (state_q == HALTED);

    // responses still owed to a squashed stream never reach the FIFO
    push = imem_rsp_valid & (drop_q == '0) & ~redir;
    pop  = instr_valid & instr_ready & ~redir;
  end

  always_comb begin
    fpc_d    = fpc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;

    if (accept && !imem_rsp_valid) begin
      out_d = out_q + CW'(1);
    end else if (!accept && imem_rsp_valid) begin
      out_d = out_q - CW'(1);
    end

    if (redir) begin
      fpc_d    = tgt;
      rsp_pc_d = tgt;
      drop_d   = out_q - CW'(imem_rsp_valid);
      cnt_d    = '0;
      wptr_d   = '0;
      rptr_d   = '0;
    end else begin
      if (accept) begin
        fpc_d = fpc_q + XLEN'(4);
      end
      if (imem_rsp_valid && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wptr_d   = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_req) state_d = HALTING;
      end
      HALTING: begin
        if (!halt_req)         state_d = RUN;
        else if (out_q == '0)  state_d = HALTED;
      end
      HALTED: begin
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr_q] <= imem_rsp_data;
      pc_mem[wptr_q]   <= rsp_pc_q;
    end
  end

endmodule
